// File: rtl/quiz_ctrl_n.sv
// quiz_ctrl_n: N-player quiz controller with countdown, first-press arbitration and per-player scores
module quiz_ctrl_n #(
    parameter int N_PLAYERS  = 4,
    parameter int TIME_W     = 5,
    parameter int ANS_TIME   = 20,
    parameter int CLK_DIV    = 50000000,
    parameter int SCORE_W    = 7,
    parameter int INIT_SCORE = 10,
    parameter int PTS_RIGHT  = 1,
    parameter int PTS_WRONG  = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           startgame,
    input  logic                           endgame,
    input  logic                           starttimer,
    input  logic                           stoptime,
    input  logic                           yes,
    input  logic                           no,
    input  logic                           startset,
    input  logic                           endset,
    input  logic [N_PLAYERS-1:0]           buzz,
    output logic                           show_ready,
    output logic                           show_time,
    output logic                           show_who,
    output logic                           show_set,
    output logic                           show_score,
    output logic [$clog2(N_PLAYERS)-1:0]   winner,
    output logic [TIME_W-1:0]              time_left,
    output logic                           timeout,
    output logic [N_PLAYERS-1:0]           foul,
    output logic [N_PLAYERS*SCORE_W-1:0]   score
);
    localparam int WW = $clog2(N_PLAYERS);
    localparam int PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);
    localparam logic [SCORE_W:0] SMAX = {1'b0, {SCORE_W{1'b1}}};
    localparam logic [SCORE_W:0] PR = (SCORE_W + 1)'(PTS_RIGHT);
    localparam logic [SCORE_W:0] PWR = (SCORE_W + 1)'(PTS_WRONG);

    // State encoding doubles as the one-hot show_* flags, so the flags are the state register itself
    typedef enum logic [4:0] {
        IDLE   = 5'b00000,
        READY  = 5'b00001,
        ARMED  = 5'b00010,
        ANSWER = 5'b00100,
        SET    = 5'b01000,
        OVER   = 5'b10000
    } state_t;

    state_t state;
    logic [N_PLAYERS-1:0] buzz_q;
    logic [N_PLAYERS-1:0] bedge;
    logic [PW-1:0] pre;
    logic [SCORE_W-1:0] sc [N_PLAYERS];
    logic [WW-1:0] first;

    assign {show_score, show_set, show_who, show_time, show_ready} = state;
    assign bedge = buzz & ~buzz_q;

    for (genvar g = 0; g < N_PLAYERS; g++) begin : g_score
        assign score[g*SCORE_W +: SCORE_W] = sc[g];
    end

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] s, input logic [SCORE_W:0] inc);
        logic [SCORE_W:0] sum;
        sum = {1'b0, s} + inc;
        return (sum > SMAX) ? SMAX[SCORE_W-1:0] : sum[SCORE_W-1:0];
    endfunction

    function automatic logic [SCORE_W-1:0] floor_sub(input logic [SCORE_W-1:0] s, input logic [SCORE_W:0] dec);
        logic [SCORE_W:0] dif;
        dif = {1'b0, s} - dec;
        return ({1'b0, s} < dec) ? '0 : dif[SCORE_W-1:0];
    endfunction

    // Lowest-index buzz edge wins arbitration
    always_comb begin
        first = '0;
        for (int i = N_PLAYERS - 1; i >= 0; i--)
            if (bedge[i]) first = i[WW-1:0];
    end

    // Phase sequencing, countdown, arbitration and scoring
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            buzz_q    <= '0;
            pre       <= '0;
            winner    <= '0;
            time_left <= '0;
            timeout   <= 1'b0;
            foul      <= '0;
            for (int i = 0; i < N_PLAYERS; i++) sc[i] <= '0;
        end else begin
            buzz_q  <= buzz;
            timeout <= 1'b0;
            foul    <= '0;
            if (endgame && state != IDLE) begin
                state <= OVER;
            end else if (startgame && (state == IDLE || state == OVER)) begin
                state  <= READY;
                winner <= '0;
                for (int i = 0; i < N_PLAYERS; i++) sc[i] <= SCORE_W'(INIT_SCORE);
            end else begin
                case (state)
                    READY: begin
                        foul <= bedge;
                        if (starttimer) begin
                            state     <= ARMED;
                            time_left <= TIME_W'(ANS_TIME);
                            pre       <= '0;
                        end else if (startset) begin
                            state <= SET;
                        end
                    end
                    ARMED: begin
                        if (|bedge) begin
                            winner <= first;
                            state  <= ANSWER;
                        end else if (stoptime) begin
                            state <= READY;
                        end else begin
                            pre <= (pre == PMAX) ? '0 : pre + 1'b1;
                            if (pre == PMAX) begin
                                time_left <= time_left - 1'b1;
                                if (time_left == TIME_W'(1)) begin
                                    timeout <= 1'b1;
                                    state   <= READY;
                                end
                            end
                        end
                    end
                    ANSWER: begin
                        if (yes != no) state <= READY;
                        for (int i = 0; i < N_PLAYERS; i++)
                            if (winner == i[WW-1:0] && yes != no)
                                sc[i] <= yes ? sat_add(sc[i], PR) : floor_sub(sc[i], PWR);
                    end
                    SET: begin
                        for (int i = 0; i < N_PLAYERS; i++)
                            if (bedge[i]) sc[i] <= sat_add(sc[i], (SCORE_W + 1)'(1));
                        if (endset) state <= READY;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_quiz_ctrl_n.sv
// tb_quiz_ctrl_n: randomized and directed checks of quiz_ctrl_n against a phase-level reference model
module tb_quiz_ctrl_n;
    localparam int NP = 4, TW = 5, AT = 5, CD = 4, SW = 7, IS = 10;
    localparam int P_IDLE = 0, P_READY = 1, P_ARMED = 2, P_ANSWER = 3, P_SET = 4, P_OVER = 5;

    logic clk = 0, rst_n = 0;
    logic startgame = 0, endgame = 0, starttimer = 0, stoptime = 0;
    logic yes = 0, no = 0, startset = 0, endset = 0;
    logic [NP-1:0] buzz = 0;
    logic show_ready, show_time, show_who, show_set, show_score, timeout;
    logic [1:0] winner;
    logic [TW-1:0] time_left;
    logic [NP-1:0] foul;
    logic [NP*SW-1:0] score;

    int tests = 0, fails = 0;
    int m_ph, m_win, m_time, m_cnt, m_to, m_foul, m_prev;
    int m_sc[NP];
    int to_seen;

    quiz_ctrl_n #(.N_PLAYERS(NP), .TIME_W(TW), .ANS_TIME(AT), .CLK_DIV(CD), .SCORE_W(SW),
                  .INIT_SCORE(IS), .PTS_RIGHT(1), .PTS_WRONG(1)) dut (
        .clk(clk), .rst_n(rst_n), .startgame(startgame), .endgame(endgame),
        .starttimer(starttimer), .stoptime(stoptime), .yes(yes), .no(no),
        .startset(startset), .endset(endset), .buzz(buzz),
        .show_ready(show_ready), .show_time(show_time), .show_who(show_who),
        .show_set(show_set), .show_score(show_score), .winner(winner),
        .time_left(time_left), .timeout(timeout), .foul(foul), .score(score)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sc_of(input int i);
        return int'(score[i*SW +: SW]);
    endfunction

    task automatic m_reset();
        m_ph = P_IDLE; m_win = 0; m_time = 0; m_cnt = 0; m_to = 0; m_foul = 0; m_prev = 0;
        foreach (m_sc[i]) m_sc[i] = 0;
    endtask

    task automatic m_step();
        int e;
        e = int'(buzz) & ~m_prev;
        m_prev = int'(buzz);
        m_to = 0;
        m_foul = 0;
        if (endgame && m_ph != P_IDLE) m_ph = P_OVER;
        else if (startgame && (m_ph == P_IDLE || m_ph == P_OVER)) begin
            m_ph = P_READY; m_win = 0;
            foreach (m_sc[i]) m_sc[i] = IS;
        end else if (m_ph == P_READY) begin
            m_foul = e;
            if (starttimer) begin m_ph = P_ARMED; m_time = AT; m_cnt = 0; end
            else if (startset) m_ph = P_SET;
        end else if (m_ph == P_ARMED) begin
            if (e != 0) begin
                for (int i = NP - 1; i >= 0; i--) if (e[i]) m_win = i;
                m_ph = P_ANSWER;
            end else if (stoptime) m_ph = P_READY;
            else begin
                m_cnt++;
                if (m_cnt % CD == 0) begin
                    m_time--;
                    if (m_time == 0) begin m_to = 1; m_ph = P_READY; end
                end
            end
        end else if (m_ph == P_ANSWER) begin
            if (yes && !no) begin m_sc[m_win] = (m_sc[m_win] + 1 > 127) ? 127 : m_sc[m_win] + 1; m_ph = P_READY; end
            if (no && !yes) begin m_sc[m_win] = (m_sc[m_win] < 1) ? 0 : m_sc[m_win] - 1; m_ph = P_READY; end
        end else if (m_ph == P_SET) begin
            for (int i = 0; i < NP; i++) if (e[i]) m_sc[i] = (m_sc[i] + 1 > 127) ? 127 : m_sc[i] + 1;
            if (endset) m_ph = P_READY;
        end
    endtask

    task automatic compare();
        check("show", {show_score, show_set, show_who, show_time, show_ready},
              (m_ph == P_IDLE) ? 0 : (1 << (m_ph - 1)));
        check("winner", winner, m_win);
        check("time_left", time_left, m_time);
        check("timeout", timeout, m_to);
        check("foul", foul, m_foul);
        for (int i = 0; i < NP; i++) check($sformatf("score%0d", i), sc_of(i), m_sc[i]);
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst_n) m_reset(); else m_step();
        #1;
        compare();
        if (timeout) to_seen++;
    endtask

    task automatic clr();
        startgame = 0; endgame = 0; starttimer = 0; stoptime = 0;
        yes = 0; no = 0; startset = 0; endset = 0;
    endtask

    task automatic press(input int idx);
        buzz = 4'(1 << idx); step();
        buzz = 0; step();
    endtask

    task automatic round(input int idx, input logic y, input logic n);
        starttimer = 1; step(); starttimer = 0;
        press(idx);
        yes = y; no = n; step(); clr();
    endtask

    task automatic async_reset();
        rst_n = 0; #1;
        m_reset();
        compare();
        step();
        rst_n = 1;
    endtask

    initial begin
        m_reset();
        repeat (3) step();
        check("reset_show", {show_score, show_set, show_who, show_time, show_ready}, 0);
        rst_n = 1;
        step();
        startgame = 1; step(); startgame = 0;
        check("start_ready", show_ready, 1);
        check("start_score", score, {4{7'd10}});
        starttimer = 1; step(); starttimer = 0;
        check("armed_time", time_left, AT);
        to_seen = 0;
        for (int i = 0; i < 40 && !show_ready; i++) step();
        check("timeout_cnt", to_seen, 1);
        check("timeout_ready", show_ready, 1);
        starttimer = 1; step(); starttimer = 0;
        step();
        buzz = 4'b1010; step();
        check("arb_winner", winner, 1);
        check("arb_who", show_who, 1);
        buzz = 0; step();
        yes = 1; step(); clr();
        check("yes_score1", sc_of(1), 11);
        round(1, 0, 1);
        check("no_score1", sc_of(1), 10);
        step();
        buzz = 4'b0100; step(); buzz = 0;
        check("foul_pulse", foul, 4'b0100);
        step();
        check("foul_clear", foul, 0);
        startset = 1; step(); startset = 0;
        repeat (3) press(3);
        endset = 1; step(); clr();
        check("set_score3", sc_of(3), 13);
        startset = 1; step(); startset = 0;
        repeat (120) press(0);
        endset = 1; step(); clr();
        round(0, 1, 0);
        check("sat_high", sc_of(0), 127);
        repeat (11) round(1, 0, 1);
        check("sat_low", sc_of(1), 0);
        starttimer = 1; step(); starttimer = 0;
        press(2);
        yes = 1; no = 1; step(); clr();
        check("yesno_stay", show_who, 1);
        yes = 1; step(); clr();
        for (int c = 0; c < 4000; c++) begin
            int r;
            r = $urandom_range(0, 255);
            startgame = (r < 12); endgame = (r == 20);
            starttimer = $urandom_range(0, 7) == 0; stoptime = $urandom_range(0, 15) == 0;
            yes = $urandom_range(0, 5) == 0; no = $urandom_range(0, 5) == 0;
            startset = $urandom_range(0, 15) == 0; endset = $urandom_range(0, 7) == 0;
            if ($urandom_range(0, 3) == 0) buzz = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            if ($urandom_range(0, 999) == 0) async_reset();
            else step();
        end
        clr(); buzz = 0;
        step();
        endgame = 1; step(); endgame = 0;
        startgame = 1; step(); startgame = 0;
        endgame = 1; step(); endgame = 0;
        check("endgame_over", show_score, 1);
        startgame = 1; step(); startgame = 0;
        starttimer = 1; step(); starttimer = 0;
        repeat (5) step();
        async_reset();
        check("rst_mid_armed", {show_time, time_left, score}, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
